// File: rtl/count_game_pkg.sv
// Shared encodings for the match tracker: game/match result codes and FSM states.
// Pure definitions, no logic.
package count_game_pkg;

   localparam logic [1:0] WIN  = 2'b10;
   localparam logic [1:0] LOSE = 2'b01;
   localparam logic [1:0] NONE = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   // Games needed to take a best-of-len match.
   function automatic int games_needed(input int len);
      return len / 2 + 1;
   endfunction

endpackage

// File: rtl/gameover_edge.sv
// Rising-edge detector on the counter's GAMEOVER level; one-cycle game_evt per high level.
// Combinational event against a registered copy; no backpressure.
module gameover_edge (
   input  logic clk,
   input  logic rst,
   input  logic gameover,
   output logic game_evt
);

   logic gameover_q;
   logic gameover_d;

   always_comb begin
      gameover_d = gameover;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gameover_q <= 1'b0;
      end else begin
         gameover_q <= gameover_d;
      end
   end

   assign game_evt = gameover & ~gameover_q;

endmodule

// File: rtl/game_match_tracker.sv
// Best-of-MATCH_LEN match tracker: tallies game results, reports the match winner.
// Tallies/result update one edge after a GAMEOVER rise; result held until match_ready.
module game_match_tracker
   import count_game_pkg::*;
#(
   parameter int MATCH_LEN = 5,
   parameter int TW        = $clog2(MATCH_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          GAMEOVER,
   input  logic [1:0]    WHO,
   output logic          game_clear,
   output logic [TW-1:0] games_won,
   output logic [TW-1:0] games_lost,
   output logic          match_valid,
   input  logic          match_ready,
   output logic [1:0]    match_winner,
   output logic          busy,
   output logic          err
);

   localparam logic [TW-1:0] NEED = TW'(games_needed(MATCH_LEN));

   logic          game_evt;
   state_t        state_q,  state_d;
   logic [TW-1:0] won_q,    won_d;
   logic [TW-1:0] lost_q,   lost_d;
   logic [1:0]    winner_q, winner_d;
   logic          valid_q,  valid_d;
   logic          clear_q,  clear_d;
   logic          err_q,    err_d;

   gameover_edge u_edge (
      .clk      (clk),
      .rst      (rst),
      .gameover (GAMEOVER),
      .game_evt (game_evt)
   );

   always_comb begin
      state_d  = state_q;
      won_d    = won_q;
      lost_d   = lost_q;
      winner_d = winner_q;
      valid_d  = valid_q;
      err_d    = err_q;
      clear_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A same-cycle event is dropped: only start is acted on here.
            if (start) begin
               state_d  = ST_PLAY;
               won_d    = '0;
               lost_d   = '0;
               winner_d = NONE;
               err_d    = 1'b0;
            end
         end
         ST_PLAY: begin
            if (game_evt) begin
               clear_d = 1'b1;
               if (WHO == WIN) begin
                  won_d = won_q + TW'(1);
                  if (won_d == NEED) begin
                     state_d  = ST_REPORT;
                     valid_d  = 1'b1;
                     winner_d = WIN;
                  end
               end else if (WHO == LOSE) begin
                  lost_d = lost_q + TW'(1);
                  if (lost_d == NEED) begin
                     state_d  = ST_REPORT;
                     valid_d  = 1'b1;
                     winner_d = LOSE;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_REPORT: begin
            if (match_ready) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         won_q    <= '0;
         lost_q   <= '0;
         winner_q <= NONE;
         valid_q  <= 1'b0;
         clear_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         won_q    <= won_d;
         lost_q   <= lost_d;
         winner_q <= winner_d;
         valid_q  <= valid_d;
         clear_q  <= clear_d;
         err_q    <= err_d;
      end
   end

   assign game_clear   = clear_q;
   assign games_won    = won_q;
   assign games_lost   = lost_q;
   assign match_winner = winner_q;
   assign match_valid  = valid_q;
   assign err          = err_q;
   assign busy         = (state_q == ST_PLAY);

endmodule
